// File: rtl/pwl_act_pipe.sv
// Streaming softplus/sigmoid PWL evaluator over a writable |x| coefficient table; 3-cycle latency, 1 sample/cycle.
// Backpressure: one global enable (out_ready | ~out_valid) holds every stage; in_ready mirrors it.
module pwl_act_pipe #(
    parameter int DATA_W    = 16,
    parameter int FRAC_W    = 8,
    parameter int SEG_SHIFT = 8,
    parameter int NUM_SEG   = 8,
    parameter int AW        = $clog2(NUM_SEG)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_data,
    input  logic                     in_mode,
    input  logic                     coef_we,
    input  logic        [AW-1:0]     coef_addr,
    input  logic signed [DATA_W-1:0] coef_grad,
    input  logic signed [DATA_W-1:0] coef_off,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] out_data
);

    localparam int YW = DATA_W + 2;
    localparam int ZW = DATA_W + 3;
    localparam logic signed [YW-1:0] ONE_Y    = YW'(1 << FRAC_W);
    localparam logic signed [ZW-1:0] ONE_Z    = ZW'(1 << FRAC_W);
    localparam logic signed [ZW-1:0] YMAX     = ZW'((1 << (DATA_W - 1)) - 1);
    localparam logic        [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};

    logic en;
    assign en       = out_ready | ~out_valid;
    assign in_ready = en;

    logic signed [DATA_W-1:0] grad_tbl [NUM_SEG];
    logic signed [DATA_W-1:0] off_tbl  [NUM_SEG];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_SEG; i++) begin
                grad_tbl[i] <= '0;
                off_tbl[i]  <= '0;
            end
        end else if (coef_we) begin
            grad_tbl[coef_addr] <= coef_grad;
            off_tbl[coef_addr]  <= coef_off;
        end
    end

    // Stage 1: magnitude, segment split and table lookup
    logic        [DATA_W-1:0] a_c, idx_c;
    logic                     sat_c;
    logic signed [DATA_W-1:0] grad_rd, off_rd;

    always_comb begin
        a_c     = in_data[DATA_W-1] ? (~in_data + 1'b1) : in_data;
        idx_c   = a_c >> SEG_SHIFT;
        sat_c   = (idx_c >= DATA_W'(NUM_SEG)) || (in_data == MOST_NEG);
        grad_rd = '0;
        off_rd  = '0;
        if (!sat_c) begin
            grad_rd = grad_tbl[idx_c[AW-1:0]];
            off_rd  = off_tbl[idx_c[AW-1:0]];
        end
    end

    logic                     v1, neg1, sat1, mode1;
    logic        [DATA_W-1:0] a1;
    logic     [SEG_SHIFT-1:0] t1;
    logic signed [DATA_W-1:0] grad1, off1;

    // Stage 2: segment interpolation with floor shift
    logic signed [2*DATA_W-1:0] prod;
    logic signed [YW-1:0]       ypos_c;

    always_comb begin
        prod   = $signed({{DATA_W{grad1[DATA_W-1]}}, grad1})
               * $signed({{(2*DATA_W-SEG_SHIFT){1'b0}}, t1});
        ypos_c = YW'(off1) + YW'(prod >>> FRAC_W);
        if (sat1) begin
            ypos_c = mode1 ? ONE_Y : $signed({2'b00, a1});
        end
    end

    logic                     v2, neg2, mode2;
    logic        [DATA_W-1:0] a2;
    logic signed [YW-1:0]     ypos2;

    // Stage 3: symmetry reconstruction and clamp to [0, max positive]
    logic signed [ZW-1:0] yp_z, a_z, y_c;
    logic        [DATA_W-1:0] y_clamp;

    always_comb begin
        yp_z = ZW'(ypos2);
        // Signed view of |x|: only the most-negative input wraps, driving softplus to full scale.
        a_z  = ZW'($signed(a2));
        if (!neg2)      y_c = yp_z;
        else if (mode2) y_c = ONE_Z - yp_z;
        else            y_c = yp_z - a_z;
        if (y_c[ZW-1])       y_clamp = '0;
        else if (y_c > YMAX) y_clamp = YMAX[DATA_W-1:0];
        else                 y_clamp = y_c[DATA_W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1 <= 1'b0; neg1 <= 1'b0; sat1 <= 1'b0; mode1 <= 1'b0;
            a1 <= '0; t1 <= '0; grad1 <= '0; off1 <= '0;
            v2 <= 1'b0; neg2 <= 1'b0; mode2 <= 1'b0; a2 <= '0; ypos2 <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (en) begin
            v1    <= in_valid;
            neg1  <= in_data[DATA_W-1];
            sat1  <= sat_c;
            mode1 <= in_mode;
            a1    <= a_c;
            t1    <= a_c[SEG_SHIFT-1:0];
            grad1 <= grad_rd;
            off1  <= off_rd;

            v2    <= v1;
            neg2  <= neg1;
            mode2 <= mode1;
            a2    <= a1;
            ypos2 <= ypos_c;

            out_valid <= v2;
            out_data  <= y_clamp;
        end
    end

endmodule

// File: tb/tb_pwl_act_pipe.sv
// Bench for pwl_act_pipe: spec vectors, hand-written stall/collision/reset sequences, random stream vs arithmetic model.
module tb_pwl_act_pipe;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid, in_ready, in_mode;
    logic signed [15:0] in_data;
    logic               coef_we;
    logic        [2:0]  coef_addr;
    logic signed [15:0] coef_grad, coef_off;
    logic               out_valid, out_ready;
    logic signed [15:0] out_data;

    pwl_act_pipe dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_mode(in_mode),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_grad(coef_grad), .coef_off(coef_off),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int mdl_grad [8];
    int mdl_off  [8];
    int exp_q [$];
    int acc_q [$];
    int got_q [$];
    bit last_acc;

    typedef struct {
        bit          we;
        logic [15:0] grad;
        logic [15:0] off;
        logic [15:0] x;
        bit          mode;
        logic [15:0] want;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input int got, input int want);
        n_tests++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
        end
    endtask

    function automatic int fdiv256(input int n);
        int q = n / 256;
        if ((n % 256 != 0) && (n < 0)) q = q - 1;
        return q;
    endfunction

    // Reference: softplus/sigmoid PWL in plain integer arithmetic
    function automatic int ref_y(input int x, input int mode);
        int a, seg, pos, y;
        if (x == -32768) return (mode != 0) ? 0 : 32767;
        a   = (x < 0) ? -x : x;
        seg = a / 256;
        if (seg >= 8) pos = (mode != 0) ? 256 : a;
        else          pos = mdl_off[seg] + fdiv256(mdl_grad[seg] * (a % 256));
        if (x >= 0)         y = pos;
        else if (mode != 0) y = 256 - pos;
        else                y = pos - a;
        if (y < 0)     y = 0;
        if (y > 32767) y = 32767;
        return y;
    endfunction

    task automatic clear_model();
        exp_q.delete();
        acc_q.delete();
        for (int i = 0; i < 8; i++) begin
            mdl_grad[i] = 0;
            mdl_off[i]  = 0;
        end
    endtask

    // One clock: score transfers that happen at the coming edge, then check stall hold.
    task automatic tick();
        bit held;
        int hd;
        #1;
        if (out_valid && out_ready) begin
            got_q.push_back(int'(out_data));
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL spurious_out: got 0x%0h with no sample pending", out_data);
            end else begin
                check("data", int'(out_data), exp_q.pop_front());
                check("latency_ge3", int'((cyc - acc_q.pop_front()) >= 3), 1);
            end
        end
        last_acc = in_valid && in_ready;
        if (last_acc) begin
            exp_q.push_back(ref_y(int'(in_data), int'(in_mode)));
            acc_q.push_back(cyc);
        end
        if (coef_we) begin
            mdl_grad[coef_addr] = int'(coef_grad);
            mdl_off[coef_addr]  = int'(coef_off);
        end
        held = out_valid && !out_ready;
        hd   = int'(out_data);
        if (held) check("in_ready_stall", int'(in_ready), 0);
        @(posedge clk);
        cyc++;
        @(negedge clk);
        if (held) begin
            check("hold_valid", int'(out_valid), 1);
            check("hold_data", int'(out_data), hd);
        end
    endtask

    task automatic write_coef(input int addr, input int g, input int o);
        coef_we   = 1'b1;
        coef_addr = 3'(addr);
        coef_grad = 16'(g);
        coef_off  = 16'(o);
        tick();
        coef_we = 1'b0;
    endtask

    task automatic send(input int x, input bit mode);
        in_valid = 1'b1;
        in_data  = 16'(x);
        in_mode  = mode;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_got(input int n);
        int k = 0;
        while (got_q.size() < n && k < 50) begin
            tick();
            k++;
        end
        if (got_q.size() < n) begin
            n_tests++;
            n_fail++;
            $display("FAIL timeout: got %0d results, expected %0d", got_q.size(), n);
        end
    endtask

    function automatic int pop_got();
        if (got_q.size() == 0) return -1;
        return got_q.pop_front();
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int sent, stall, k, mag;
        bit seen;
        logic [15:0] xs [5];

        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_mode = 1'b0;
        coef_we = 1'b0; coef_addr = '0; coef_grad = '0; coef_off = '0; out_ready = 1'b1;
        clear_model();
        repeat (2) @(negedge clk);
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_data", int'(out_data), 0);
        rst = 1'b0;
        @(negedge clk);

        vecs[0] = '{1'b1, 16'h009F, 16'h00B1, 16'h0080, 1'b0, 16'h0100};
        vecs[1] = '{1'b0, 16'h0000, 16'h0000, 16'hFF80, 1'b0, 16'h0080};
        vecs[2] = '{1'b1, 16'h003B, 16'h0080, 16'h0080, 1'b1, 16'h009D};
        vecs[3] = '{1'b0, 16'h0000, 16'h0000, 16'hFF80, 1'b1, 16'h0063};
        vecs[4] = '{1'b0, 16'h0000, 16'h0000, 16'h00FF, 1'b1, 16'h00BA};
        vecs[5] = '{1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h0080};
        vecs[6] = '{1'b0, 16'h0000, 16'h0000, 16'h0900, 1'b0, 16'h0900};
        vecs[7] = '{1'b0, 16'h0000, 16'h0000, 16'hF700, 1'b0, 16'h0000};
        vecs[8] = '{1'b0, 16'h0000, 16'h0000, 16'h0A00, 1'b1, 16'h0100};
        vecs[9] = '{1'b0, 16'h0000, 16'h0000, 16'h8000, 1'b0, 16'h7FFF};

        for (int i = 0; i < 10; i++) begin
            if (vecs[i].we) write_coef(0, int'(vecs[i].grad), int'(vecs[i].off));
            got_q.delete();
            send(int'(vecs[i].x), vecs[i].mode);
            wait_got(1);
            check($sformatf("vec%0d", i), pop_got(), int'(vecs[i].want));
        end

        // Exact 3-cycle latency with two back-to-back samples
        write_coef(0, 'h009F, 'h00B1);
        got_q.delete();
        in_valid = 1'b1; in_data = 16'sh0080; in_mode = 1'b0;
        tick();
        in_data = 16'hFF80;
        tick();
        in_valid = 1'b0;
        check("lat_cycle2", int'(out_valid), 0);
        tick();
        check("lat_cycle3", int'(out_valid), 1);
        check("lat_data", int'(out_data), 'h0100);
        wait_got(2);
        check("b2b_first", pop_got(), 'h0100);
        check("b2b_second", pop_got(), 'h0080);

        // Backpressure: 4-cycle stall right after the first result appears
        xs[0] = 16'h0010; xs[1] = 16'h0120; xs[2] = 16'hFEE0; xs[3] = 16'h0300; xs[4] = 16'h0455;
        got_q.delete();
        sent = 0; stall = 0; seen = 1'b0; k = 0;
        while ((sent < 5 || got_q.size() < 5) && k < 60) begin
            in_valid = (sent < 5);
            if (sent < 5) begin
                in_data = xs[sent];
                in_mode = sent[0];
            end
            if (out_valid && !seen) begin
                seen  = 1'b1;
                stall = 4;
            end
            out_ready = (stall == 0);
            tick();
            if (last_acc) sent++;
            if (stall > 0) stall--;
            k++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        check("bp_result_count", got_q.size(), 5);
        check("bp_queue_empty", exp_q.size(), 0);

        // Coefficient write colliding with a lookup of the same segment
        write_coef(0, 'h003B, 'h0080);
        got_q.delete();
        in_valid = 1'b1; in_data = 16'sh0040; in_mode = 1'b0;
        coef_we = 1'b1; coef_addr = 3'd0; coef_grad = 16'sh0100; coef_off = 16'sh0010;
        tick();
        coef_we = 1'b0;
        tick();
        in_valid = 1'b0;
        wait_got(2);
        check("collide_old", pop_got(), 'h008E);
        check("collide_new", pop_got(), 'h0050);

        // Reset with samples in flight
        got_q.delete();
        in_valid = 1'b1; in_mode = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_data = 16'(i * 'h0030 + 'h0020);
            tick();
        end
        in_valid = 1'b0;
        check("pre_rst_valid", int'(out_valid), 1);
        rst = 1'b1;
        #1;
        check("rst_valid_drop", int'(out_valid), 0);
        check("rst_data_zero", int'(out_data), 0);
        check("rst_in_ready_hi", int'(in_ready), 1);
        clear_model();
        got_q.delete();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("no_stale_valid", int'(out_valid), 0);
        end
        check("no_stale_count", got_q.size(), 0);
        send('h0080, 1'b0);
        wait_got(1);
        check("cleared_tbl_sp", pop_got(), 0);
        send('hFF80, 1'b1);
        wait_got(1);
        check("cleared_tbl_sig_neg", pop_got(), 'h0100);

        // Random stream with random stalls and table writes
        for (int i = 0; i < 400; i++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) == 0) begin
                in_data = 16'($urandom);
            end else begin
                mag     = int'($urandom_range(0, 'h0A00));
                in_data = ($urandom_range(0, 1) == 1) ? 16'(-mag) : 16'(mag);
            end
            in_mode   = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            coef_we   = ($urandom_range(0, 3) == 0);
            coef_addr = 3'($urandom_range(0, 7));
            coef_grad = 16'($urandom);
            coef_off  = 16'($urandom);
            tick();
        end
        coef_we = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        k = 0;
        while (exp_q.size() > 0 && k < 20) begin
            tick();
            k++;
        end
        check("rand_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
